// File: rtl/trig_pulse_gen_pkg.sv
// Shared definitions for the trigger pulse generator: FSM state encoding,
// the start condition, and a small constant helper for sizing the phase counter.
package trig_pulse_gen_pkg;

   // FSM state encoding.
   //   IDLE : no pulse in flight, pulse_out low, busy low.
   //   HIGH : pulse_out high for HIGH_CYCLES cycles.
   //   LOW  : guaranteed low gap of LOW_CYCLES cycles after each pulse.
   //
   // Start condition (evaluated every cycle):
   //   start = (state == IDLE || (state == LOW && on its last cycle))
   //           && (trig_in || pend_cnt != 0)
   // A start from the last LOW cycle goes straight to HIGH, so back-to-back
   // pulses have a period of exactly HIGH_CYCLES + LOW_CYCLES.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   // Larger of two integers; used at elaboration time to size the phase counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/trig_pulse_gen_sat_counter.sv
// Saturating up/down counter holding the queue of pending pulse requests.
// An increment and a decrement in the same cycle cancel out. An increment
// at full scale without a decrement is dropped and flagged on sat_drop
// (combinational, same cycle as the dropped request).
module sat_counter
   import trig_pulse_gen_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         sat_drop
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: net change of inc - dec, clamped at both ends.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // branch would otherwise infer a latch.
      count_d  = count_q;
      sat_drop = 1'b0;
      if (inc && !dec) begin
         if (count_q == CNT_MAX) begin
            sat_drop = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (!inc && dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register with synchronous reset discarding all queued requests.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would create order-dependent simulation races.
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger-to-pulse generator. Each accepted request yields one fixed-width
// high pulse followed by a guaranteed low gap; requests arriving while a
// pulse is in flight are queued in a saturating counter and replayed.
module trig_pulse_gen
   import trig_pulse_gen_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 4,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trig_in,
   output logic              pulse_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              overflow
);

   localparam int PH_W = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
   localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
   localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYCLES - 1);

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              pulse_out_q, pulse_out_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;
   logic              low_last;
   logic              start;
   logic              sat_drop;

   // Pending-request queue: each trig_in adds one, each start consumes one.
   sat_counter #(
      .W (PEND_W)
   ) u_pend (
      .clk      (clk),
      .rst      (rst),
      .inc      (trig_in),
      .dec      (start),
      .count    (pend_cnt),
      .sat_drop (sat_drop)
   );

   // Next-state, phase count and registered-output values.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      low_last    = (state_q == LOW) && (phase_q == LOW_LAST);
      start       = ((state_q == IDLE) || low_last) && (trig_in || (pend_cnt != '0));

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HIGH;
               phase_d = '0;
            end
         end
         HIGH: begin
            if (phase_q == HIGH_LAST) begin
               state_d = LOW;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         LOW: begin
            if (low_last) begin
               state_d = start ? HIGH : IDLE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase

      // Outputs are registered copies of the upcoming state, so they line
      // up exactly with the state register.
      pulse_out_d = (state_d == HIGH);
      busy_d      = (state_d != IDLE);
      overflow_d  = sat_drop;
   end

   // State, phase and output registers; reset truncates any pulse in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         pulse_out_q <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         pulse_out_q <= pulse_out_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pulse_out = pulse_out_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed bench for trig_pulse_gen. One instance uses default parameters,
// a second uses HIGH_CYCLES=LOW_CYCLES=1. Cycle numbers are counted from the
// first cycle after reset release; expected values are hand-derived per cycle.
module tb_trig_pulse_gen;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, trig_a, pulse_a, busy_a, ovf_a;
   logic [2:0] pend_a;
   logic       rst_b, trig_b, pulse_b, busy_b, ovf_b;
   logic [2:0] pend_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int edges = 0;
   logic prev_pulse = 1'b0;

   trig_pulse_gen #(
      .HIGH_CYCLES (4),
      .LOW_CYCLES  (4),
      .PEND_W      (3)
   ) u_dut (
      .clk       (clk),
      .rst       (rst_a),
      .trig_in   (trig_a),
      .pulse_out (pulse_a),
      .busy      (busy_a),
      .pend_cnt  (pend_a),
      .overflow  (ovf_a)
   );

   trig_pulse_gen #(
      .HIGH_CYCLES (1),
      .LOW_CYCLES  (1),
      .PEND_W      (3)
   ) u_dut_min (
      .clk       (clk),
      .rst       (rst_b),
      .trig_in   (trig_b),
      .pulse_out (pulse_b),
      .busy      (busy_b),
      .pend_cnt  (pend_b),
      .overflow  (ovf_b)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_a(input string sc, input logic ep, input logic eb,
                          input logic [2:0] epend, input logic eovf);
      check({sc, ".pulse"}, {7'd0, pulse_a}, {7'd0, ep});
      check({sc, ".busy"},  {7'd0, busy_a},  {7'd0, eb});
      check({sc, ".pend"},  {5'd0, pend_a},  {5'd0, epend});
      check({sc, ".ovf"},   {7'd0, ovf_a},   {7'd0, eovf});
   endtask

   task automatic check_b(input string sc, input logic ep, input logic eb,
                          input logic [2:0] epend, input logic eovf);
      check({sc, ".pulse"}, {7'd0, pulse_b}, {7'd0, ep});
      check({sc, ".busy"},  {7'd0, busy_b},  {7'd0, eb});
      check({sc, ".pend"},  {5'd0, pend_b},  {5'd0, epend});
      check({sc, ".ovf"},   {7'd0, ovf_b},   {7'd0, eovf});
   endtask

   task automatic count_edge(input logic p);
      if (p && !prev_pulse) edges++;
      prev_pulse = p;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      trig_a = 1'b0;
      tick();
      tick();
      rst_a = 1'b0;
      cyc = 0;
      edges = 0;
      prev_pulse = 1'b0;
   endtask

   initial begin
      int exp_pend;
      rst_a = 1'b1;
      trig_a = 1'b0;
      rst_b = 1'b1;
      trig_b = 1'b0;

      // Single trigger at cycle 10.
      reset_a();
      for (int i = 0; i <= 22; i++) begin
         check_a("single", (cyc >= 11 && cyc <= 14), (cyc >= 11 && cyc <= 18), 3'd0, 1'b0);
         trig_a = (cyc == 10);
         tick();
      end

      // Trigger held for cycles 10..12: pulses rise at 11, 19, 27.
      reset_a();
      for (int i = 0; i <= 36; i++) begin
         if (cyc == 12)                   exp_pend = 1;
         else if (cyc >= 13 && cyc <= 18) exp_pend = 2;
         else if (cyc >= 19 && cyc <= 26) exp_pend = 1;
         else                             exp_pend = 0;
         check_a("held",
                 (cyc >= 11 && cyc <= 14) || (cyc >= 19 && cyc <= 22) || (cyc >= 27 && cyc <= 30),
                 (cyc >= 11 && cyc <= 34), 3'(exp_pend), 1'b0);
         count_edge(pulse_a);
         trig_a = (cyc >= 10 && cyc <= 12);
         tick();
      end
      check("held.edges", 8'(edges), 8'd3);

      // Trigger held for cycles 10..19: saturates at 7, one drop at cycle 19.
      reset_a();
      for (int i = 0; i <= 90; i++) begin
         if (cyc < 12)       exp_pend = 0;
         else if (cyc <= 18) exp_pend = cyc - 11;
         else if (cyc <= 26) exp_pend = 7;
         else if (cyc <= 75) exp_pend = 7 - (cyc - 19) / 8;
         else                exp_pend = 0;
         check_a("ovf",
                 (cyc >= 11 && cyc <= 78 && ((cyc - 11) % 8) < 4),
                 (cyc >= 11 && cyc <= 82), 3'(exp_pend), (cyc == 20));
         count_edge(pulse_a);
         trig_a = (cyc >= 10 && cyc <= 19);
         tick();
      end
      check("ovf.edges", 8'(edges), 8'd9);

      // Reset in cycle 12 with one request queued; trig_in in that cycle ignored.
      reset_a();
      for (int i = 0; i <= 30; i++) begin
         check_a("rst_mid", (cyc >= 11 && cyc <= 12), (cyc >= 11 && cyc <= 12),
                 3'((cyc == 12) ? 1 : 0), 1'b0);
         count_edge(pulse_a);
         trig_a = (cyc >= 10 && cyc <= 12);
         rst_a  = (cyc == 12);
         tick();
      end
      rst_a = 1'b0;
      check("rst_mid.edges", 8'(edges), 8'd1);

      // Second trigger exactly on the last LOW cycle (18): no idle gap.
      reset_a();
      for (int i = 0; i <= 30; i++) begin
         check_a("last_low", (cyc >= 11 && cyc <= 14) || (cyc >= 19 && cyc <= 22),
                 (cyc >= 11 && cyc <= 26), 3'd0, 1'b0);
         trig_a = (cyc == 10 || cyc == 18);
         tick();
      end

      // Minimum parameters: trigger held for cycles 10..29.
      trig_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b0;
      cyc = 0;
      edges = 0;
      prev_pulse = 1'b0;
      for (int i = 0; i <= 50; i++) begin
         if (cyc < 12)       exp_pend = 0;
         else if (cyc <= 24) exp_pend = (cyc - 10) / 2;
         else if (cyc <= 30) exp_pend = 7;
         else if (cyc <= 43) exp_pend = 7 - (cyc - 29) / 2;
         else                exp_pend = 0;
         check_b("min", (cyc >= 11 && cyc <= 43 && (cyc % 2) == 1),
                 (cyc >= 11 && cyc <= 44), 3'(exp_pend),
                 (cyc == 26 || cyc == 28 || cyc == 30));
         count_edge(pulse_b);
         trig_b = (cyc >= 10 && cyc <= 29);
         tick();
      end
      check("min.edges", 8'(edges), 8'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/trig_pulse_gen.md
# trig_pulse_gen

Pulse generator that turns single-cycle trigger requests into clean, fixed-width output pulses separated by a guaranteed low gap. It is the transmit side of the rising-edge detect path. Each accepted trigger produces exactly one rising edge on `pulse_out`, so a downstream rise detector sees one event per request. Requests that arrive while a pulse is in flight are queued in a saturating pending counter and replayed in order.

## Interface
- `HIGH_CYCLES`, default 4: cycles `pulse_out` stays high per pulse; must be ≥1.
- `LOW_CYCLES`, default 4: minimum low cycles after each pulse before the next may start; must be ≥1.
- `PEND_W`, default 3: width of the pending-request counter; max queued = 2^PEND_W−1.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trig_in`  in  1  request strobe. Every cycle it is high counts as one request; holding it high N cycles requests N pulses.
- `pulse_out`  out  1  generated pulse, registered.
- `busy`  out  1  high whenever state ≠ IDLE, registered.
- `pend_cnt`  out  PEND_W  queued requests not yet started, registered.
- `overflow`  out  1  one-cycle strobe: a request was dropped, registered.

## Operation
- FSM states: IDLE, HIGH, LOW. Phase counter width = $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1).
- `start` is asserted when (state==IDLE, or state==LOW on its last cycle) and (`trig_in` or `pend_cnt`≠0).
- Transitions:
  - IDLE→HIGH on `start`.
  - HIGH→LOW after HIGH_CYCLES cycles.
  - LOW→HIGH on `start` at the last LOW cycle.
  - LOW→IDLE at the last LOW cycle without `start`.
- Pending update: next = `pend_cnt` + `trig_in` − `start`.
  - A trigger and a start in the same cycle leave `pend_cnt` unchanged.
  - A start with `trig_in` low consumes one pending request.
- Saturation: if `pend_cnt`==max, `trig_in`=1 and `start`=0, the request is dropped. `pend_cnt` stays at max and `overflow` pulses high the next cycle.
- `pulse_out` = 1 exactly while in HIGH. `busy` = 1 in HIGH and LOW.
- Reset values: state IDLE, phase counter 0, `pulse_out`=0, `busy`=0, `pend_cnt`=0, `overflow`=0.
- Reset mid-operation:
  - Takes effect at the sampling edge; the pulse is truncated.
  - All queued requests are discarded.
  - `trig_in` in the reset cycle is ignored.

## Timing
- Latency: a trigger sampled in cycle t from IDLE gives `pulse_out` high in cycles t+1 .. t+HIGH_CYCLES.
- LOW phase occupies t+HIGH_CYCLES+1 .. t+HIGH_CYCLES+LOW_CYCLES.
- Back-to-back pulse period = HIGH_CYCLES+LOW_CYCLES. No idle cycle is inserted between a LOW phase and the next HIGH phase.
- `pend_cnt` and `overflow` reflect the sampled cycle's events one cycle later.
- No backpressure. `trig_in` is always accepted or counted as dropped.

## Structure
- Shared header, in a package or include file: state encoding constants IDLE=2'd0, HIGH=2'd1, LOW=2'd2, and the `start` condition documented alongside them.
- One sub-module is natural: `sat_counter` (parameter W; ports inc, dec, count, sat_drop), used for the pending queue.
- Phase counter and FSM stay in the top module.

## Test plan
All scenarios use HIGH_CYCLES=4, LOW_CYCLES=4, PEND_W=3 unless noted.
- Single trigger: `trig_in` high in cycle 10 only.
  - `pulse_out` high in cycles 11–14 and low in 15–18.
  - `busy` high 11–18; IDLE from cycle 19.
  - `pend_cnt` stays 0.
- Held trigger: `trig_in` high in cycles 10–12.
  - Pulses rise at 11, 19 and 27.
  - `pend_cnt` = 1 at 12, 2 at 13, 1 at 19, 0 at 27.
- Overflow: `trig_in` high in cycles 10–19.
  - `pend_cnt` reaches 7 at cycle 18 and holds 7 through the cycle-18 start.
  - `overflow` high at cycle 20 only.
  - Exactly 9 pulses total.
- Reset mid-pulse: trigger in cycle 10, `rst` high in cycle 12, with a queued request present.
  - From cycle 13: `pulse_out`=0, `busy`=0, `pend_cnt`=0.
  - No further pulses occur.
- Trigger on last LOW cycle: single trigger at cycle 10, second trigger at cycle 18.
  - Second pulse occupies 19–22.
  - `pend_cnt` stays 0 and `overflow` stays 0.
- Minimum parameters (HIGH_CYCLES=1, LOW_CYCLES=1): `trig_in` held high for 20 cycles.
  - `pulse_out` toggles 1,0,1,0…
  - `pend_cnt` saturates at 7 and `overflow` strobes on each drop.
  - After `trig_in` drops, every queued request drains as one pulse per 2 cycles.
